conv_weight_loader: RTL and testbench

//  Write-side counterpart of the conv weight cache: accepts a streamed weight set (kernel taps + bias)

---
 rtl/conv_weight_loader_pkg.sv | 7 +
 rtl/conv_weight_loader_weight_ram.sv | 31 +++
 rtl/conv_weight_loader.sv | 101 ++++++++++
 tb/tb_conv_weight_loader.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/conv_weight_loader_pkg.sv
// conv_weight_loader_pkg: shared widths, set length and loader FSM state encoding
package conv_weight_loader_pkg;
    localparam int CWL_DATA_WIDTH = 32;
    localparam int CWL_ADDR_WIDTH = 6;
    localparam int CWL_SET_LEN    = 10;
    typedef enum logic {S_FILL = 1'b0, S_STALL = 1'b1} ld_state_t;
endpackage

// File: rtl/conv_weight_loader_weight_ram.sv
// weight_ram_64x32: one weight bank, 1 write port + 1 registered read port
//   clk, rst_n         clock, async active-low reset (clears only the read register)
//   i_clear            sync clear of the read register
//   i_we/i_waddr/i_wdata  write port
//   i_raddr/o_rdata    read port, 1-cycle latency
module weight_ram_64x32
    import conv_weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH = CWL_DATA_WIDTH,
    parameter int ADDR_WIDTH = CWL_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rdata <= '0;
        else        r_rdata <= i_clear ? '0 : r_mem[i_raddr];
    end
    assign o_rdata = r_rdata;
endmodule

// File: rtl/conv_weight_loader.sv
// conv_weight_loader: streams weight sets into a ping-pong pair of weight RAMs
//   clk, rst_n      clock, async active-low reset
//   i_clear         sync clear of flags, pointers and counter
//   i_wt_valid/i_wt_data/o_wt_ready  upstream weight stream
//   i_rd_addr/o_rd_data              read port into current read bank, 1-cycle latency
//   o_set_valid     read bank holds a complete set
//   i_set_release   reader done with current read bank
//   o_rd_bank       current read bank index
module conv_weight_loader
    import conv_weight_loader_pkg::*;
#(
    parameter int DATA_WIDTH = CWL_DATA_WIDTH,
    parameter int ADDR_WIDTH = CWL_ADDR_WIDTH,
    parameter int SET_LEN    = CWL_SET_LEN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_wt_valid,
    input  logic [DATA_WIDTH-1:0] i_wt_data,
    output logic                  o_wt_ready,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_set_valid,
    input  logic                  i_set_release,
    output logic                  o_rd_bank
);
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH+1)'(SET_LEN - 1);
    ld_state_t             r_state, w_state_nxt;
    logic                  r_wt_ready, r_wr_bank, r_rd_bank, r_rd_sel;
    logic [ADDR_WIDTH:0]   r_wr_cnt;
    logic [1:0]            r_full, w_full_rel, w_full_nxt;
    logic                  w_xfer, w_last, w_rel;
    logic [DATA_WIDTH-1:0] w_rd0, w_rd1;

    assign w_xfer     = i_wt_valid & r_wt_ready & ~i_clear;
    assign w_last     = w_xfer & (r_wr_cnt == LAST_IDX);
    assign w_rel      = i_set_release & r_full[r_rd_bank];
    // release is applied before the stall decision so a same-cycle release never stalls
    assign w_full_rel = r_full & ~(w_rel ? (2'b01 << r_rd_bank) : 2'b00);
    assign w_full_nxt = w_full_rel | (w_last ? (2'b01 << r_wr_bank) : 2'b00);

    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = (r_state == S_FILL) ? ((w_last & w_full_rel[~r_wr_bank]) ? S_STALL : S_FILL)
                                          : (r_full[r_wr_bank] ? S_STALL : S_FILL);
    end

    // ready is registered from the next state so it never depends on valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_FILL;
            r_wt_ready <= 1'b0;
        end else if (i_clear) begin
            r_state    <= S_FILL;
            r_wt_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wt_ready <= (w_state_nxt == S_FILL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_wr_cnt  <= '0;
        end else if (i_clear) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_wr_cnt  <= '0;
        end else begin
            r_full    <= w_full_nxt;
            r_wr_bank <= r_wr_bank ^ w_last;
            r_rd_bank <= r_rd_bank ^ w_rel;
            r_rd_sel  <= r_rd_bank;
            r_wr_cnt  <= w_last ? '0 : r_wr_cnt + {{ADDR_WIDTH{1'b0}}, w_xfer};
        end
    end

    weight_ram_64x32 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank0 (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_we(w_xfer & ~r_wr_bank),
        .i_waddr(r_wr_cnt[ADDR_WIDTH-1:0]), .i_wdata(i_wt_data),
        .i_raddr(i_rd_addr), .o_rdata(w_rd0)
    );
    weight_ram_64x32 #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_bank1 (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_we(w_xfer & r_wr_bank),
        .i_waddr(r_wr_cnt[ADDR_WIDTH-1:0]), .i_wdata(i_wt_data),
        .i_raddr(i_rd_addr), .o_rdata(w_rd1)
    );

    // read data is muxed by the bank that was current when the read was issued
    assign o_rd_data   = r_rd_sel ? w_rd1 : w_rd0;
    assign o_wt_ready  = r_wt_ready;
    assign o_set_valid = r_full[r_rd_bank];
    assign o_rd_bank   = r_rd_bank;
endmodule

// File: tb/tb_conv_weight_loader.sv
// tb_conv_weight_loader: directed and randomized scoreboard bench for conv_weight_loader
module tb_conv_weight_loader;
    localparam int SL = 10;
    logic        clk = 0, rst_n = 0, i_clear = 0, i_wt_valid = 0, i_set_release = 0, rd_chk = 0;
    logic [31:0] i_wt_data = 0;
    logic [5:0]  i_rd_addr = 0;
    logic        o_wt_ready, o_set_valid, o_rd_bank;
    logic [31:0] o_rd_data;
    int          checks = 0, errors = 0, acc_cnt = 0, rel_cnt = 0;
    logic [31:0] part_q[$], set_q[$], pend_q[$];

    conv_weight_loader dut (
        .clk(clk), .rst_n(rst_n), .i_clear(i_clear), .i_wt_valid(i_wt_valid),
        .i_wt_data(i_wt_data), .o_wt_ready(o_wt_ready), .i_rd_addr(i_rd_addr),
        .o_rd_data(o_rd_data), .o_set_valid(o_set_valid), .i_set_release(i_set_release),
        .o_rd_bank(o_rd_bank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: accepted words form sets of SL in order; front set is what the reader sees
    always @(posedge clk) begin
        if (!rst_n || i_clear) begin
            part_q.delete(); set_q.delete(); pend_q.delete();
            rel_cnt = 0;
        end else begin
            if (rd_chk && set_q.size() > 0) pend_q.push_back(set_q[i_rd_addr]);
            if (i_set_release && set_q.size() > 0) begin
                for (int k = 0; k < SL; k++) void'(set_q.pop_front());
                rel_cnt++;
            end
            if (i_wt_valid && o_wt_ready) begin
                acc_cnt++;
                part_q.push_back(i_wt_data);
                if (part_q.size() == SL) begin
                    set_q = {set_q, part_q};
                    part_q.delete();
                    chk("bank_overflow", 32'(set_q.size() > 2*SL), 32'd0);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (pend_q.size() > 0) chk("rd_data", o_rd_data, pend_q.pop_front());
            chk("set_valid", 32'(o_set_valid), 32'(set_q.size() > 0));
            chk("rd_bank", 32'(o_rd_bank), 32'(rel_cnt % 2));
        end
    end

    task automatic do_reset();
        rst_n = 0; i_clear = 0; i_wt_valid = 0; i_set_release = 0; rd_chk = 0; i_rd_addr = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(o_wt_ready), 0);
        chk("rst_set_valid", 32'(o_set_valid), 0);
        chk("rst_rd_bank", 32'(o_rd_bank), 0);
        chk("rst_rd_data", o_rd_data, 0);
        rst_n = 1;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] w);
        int n = 0;
        i_wt_valid = 1; i_wt_data = w;
        while (!o_wt_ready && n < 100) begin @(negedge clk); n++; end
        if (!o_wt_ready) begin
            errors++; checks++;
            $display("FAIL send_timeout: ready got 0 expected 1 for word %0h", w);
        end
        @(negedge clk);
    endtask

    task automatic send_seq(input int first, input int cnt);
        for (int i = 0; i < cnt; i++) send(32'(first + i));
        i_wt_valid = 0;
    endtask

    task automatic read_set();
        for (int a = 0; a < SL; a++) begin i_rd_addr = 6'(a); rd_chk = 1; @(negedge clk); end
        rd_chk = 0;
        @(negedge clk);
    endtask

    task automatic release_pulse();
        i_set_release = 1; @(negedge clk); i_set_release = 0;
    endtask

    initial begin
        int a0;
        logic go;
        go = 0;
        // 1: single set, valid rises right after the 10th transfer
        do_reset();
        send_seq(1, 9);
        chk("t1_valid_before", 32'(o_set_valid), 0);
        send_seq(10, 1);
        chk("t1_valid_after", 32'(o_set_valid), 1);
        chk("t1_rd_bank", 32'(o_rd_bank), 0);
        read_set();
        i_rd_addr = 4; @(negedge clk);
        chk("t1_addr4", o_rd_data, 5);
        // 2: both banks fill, upstream held, release resumes without loss
        do_reset();
        a0 = acc_cnt;
        for (int i = 1; i <= 20; i++) send(32'(i));
        i_wt_data = 21;
        chk("t2_ready_low", 32'(o_wt_ready), 0);
        repeat (3) @(negedge clk);
        chk("t2_still_low", 32'(o_wt_ready), 0);
        chk("t2_accepted", 32'(acc_cnt - a0), 20);
        release_pulse();
        @(negedge clk);
        chk("t2_ready_back", 32'(o_wt_ready), 1);
        send_seq(21, 10);
        chk("t2_accepted_all", 32'(acc_cnt - a0), 30);
        chk("t2_rd_bank", 32'(o_rd_bank), 1);
        read_set();
        release_pulse();
        read_set();
        // 3: release on the same cycle as the last word of bank1 -> no stall
        do_reset();
        send_seq(1, 19);
        i_wt_valid = 1; i_wt_data = 20; i_set_release = 1;
        @(negedge clk);
        i_wt_valid = 0; i_set_release = 0;
        chk("t3_ready", 32'(o_wt_ready), 1);
        chk("t3_rd_bank", 32'(o_rd_bank), 1);
        @(negedge clk);
        chk("t3_ready_hold", 32'(o_wt_ready), 1);
        read_set();
        // 4: release with no complete set is ignored
        do_reset();
        release_pulse();
        chk("t4_rd_bank0", 32'(o_rd_bank), 0);
        send_seq(1, 10);
        release_pulse();
        chk("t4_rd_bank1", 32'(o_rd_bank), 1);
        release_pulse();
        chk("t4_rd_bank1_kept", 32'(o_rd_bank), 1);
        chk("t4_valid", 32'(o_set_valid), 0);
        // 5: clear mid-set drops the partial set and the word on the clear cycle
        do_reset();
        send_seq(1, 5);
        i_wt_valid = 1; i_wt_data = 32'hDEAD; i_clear = 1;
        @(negedge clk);
        i_wt_valid = 0; i_clear = 0;
        chk("t5_valid", 32'(o_set_valid), 0);
        chk("t5_ready", 32'(o_wt_ready), 0);
        chk("t5_rd_data", o_rd_data, 0);
        send_seq(101, 10);
        chk("t5_rd_bank", 32'(o_rd_bank), 0);
        read_set();
        i_rd_addr = 0; @(negedge clk);
        chk("t5_addr0", o_rd_data, 101);
        // 6: asynchronous reset mid-set
        do_reset();
        send_seq(1, 10);
        i_rd_addr = 3; @(negedge clk);
        chk("t6_pre_data", o_rd_data, 4);
        send_seq(11, 3);
        i_wt_valid = 1; i_wt_data = 14;
        #2 rst_n = 0;
        #1;
        chk("t6_ready", 32'(o_wt_ready), 0);
        chk("t6_valid", 32'(o_set_valid), 0);
        chk("t6_data", o_rd_data, 0);
        chk("t6_bank", 32'(o_rd_bank), 0);
        do_reset();
        send_seq(201, 10);
        chk("t6_rec_valid", 32'(o_set_valid), 1);
        read_set();
        i_rd_addr = 0; @(negedge clk);
        chk("t6_rec_addr0", o_rd_data, 201);
        // random traffic: valid gaps, random reads and releases, rare clear
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (!i_wt_valid || go) begin
                i_wt_valid = ($urandom_range(0, 3) != 0);
                i_wt_data  = $urandom;
            end
            i_rd_addr     = 6'($urandom_range(0, SL - 1));
            rd_chk        = o_set_valid && ($urandom_range(0, 1) == 1);
            i_set_release = o_set_valid && ($urandom_range(0, 7) == 0);
            i_clear       = ($urandom_range(0, 999) == 0);
            go            = i_wt_valid && o_wt_ready;
            @(negedge clk);
        end
        i_wt_valid = 0; i_set_release = 0; rd_chk = 0; i_clear = 0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
